wb_mem_dma_reader: RTL and testbench

//  Wishbone master on the memory bus: reads a block of 32-bit words from memory (wb_bram

---
 rtl/wb_mem_dma_reader.sv | 162 ++++++++++++++++
 tb/tb_wb_mem_dma_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_dma_reader.sv
// Read-only Wishbone master: fetches a block of words from memory and streams them
// out in address order through a show-ahead FIFO, one outstanding access at a time.
module wb_mem_dma_reader #(
   parameter int unsigned FIFO_ADDR_WIDTH = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [31:0] i_base_addr,
   input  logic [23:0] i_word_count,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic        o_mem_we,
   output logic        o_mem_cyc,
   output logic        o_mem_stb,
   output logic [3:0]  o_mem_sel,
   output logic [31:0] o_mem_adr,
   output logic [31:0] o_mem_dat,
   input  logic [31:0] i_mem_dat,
   input  logic        i_mem_ack,
   input  logic        i_mem_int,
   output logic [31:0] o_data,
   output logic        o_data_valid,
   input  logic        i_data_ready
);

   localparam int unsigned Depth = 2 ** FIFO_ADDR_WIDTH;
   localparam int unsigned CntW  = FIFO_ADDR_WIDTH + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

   typedef enum logic [2:0] {StIdle, StReq, StWaitAck, StHold, StDrain} state_e;

   state_e                     state_q;
   logic [31:0]                addr_q;
   logic [23:0]                remain_q;
   logic [31:0]                tmo_q;
   logic                       busy_q, done_q, error_q, cyc_q, stb_q;
   logic [31:0]                fifo_mem [Depth];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]            cnt_q, cnt_d;
   logic                       push, pop, timeout_hit;
   logic                       unused_int;

   assign unused_int  = i_mem_int;
   assign push        = (state_q == StWaitAck) && i_mem_ack;
   assign pop         = (cnt_q != '0) && i_data_ready;
   // An ack arriving on the final timeout cycle still wins.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == StWaitAck) && !i_mem_ack &&
                        (tmo_q == 32'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (timeout_hit) begin
         cnt_d = '0;
      end else begin
         if (push) cnt_d = cnt_d + CntW'(1);
         if (pop)  cnt_d = cnt_d - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= i_mem_dat;
   end

   always_ff @(posedge clk) begin
      if (rst || timeout_hit) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + FIFO_ADDR_WIDTH'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_ADDR_WIDTH'(1);
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         remain_q <= '0;
         tmo_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // busy_q set here only for the one-cycle empty-block pulse
               busy_q <= 1'b0;
               if (i_start && !busy_q) begin
                  addr_q   <= i_base_addr;
                  remain_q <= i_word_count;
                  error_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  if (i_word_count == 24'd0) done_q <= 1'b1;
                  else state_q <= StReq;
               end
            end
            StReq: begin
               cyc_q   <= 1'b1;
               stb_q   <= 1'b1;
               tmo_q   <= '0;
               state_q <= StWaitAck;
            end
            StWaitAck: begin
               if (i_mem_ack) begin
                  stb_q    <= 1'b0;
                  addr_q   <= addr_q + 32'd1;
                  remain_q <= remain_q - 24'd1;
                  if (remain_q == 24'd1) begin
                     cyc_q   <= 1'b0;
                     state_q <= StDrain;
                  end else if (cnt_d == FullCnt) begin
                     state_q <= StHold;
                  end else begin
                     state_q <= StReq;
                  end
               end else if (timeout_hit) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  done_q  <= 1'b1;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
            StHold: begin
               if (cnt_d != FullCnt) state_q <= StReq;
            end
            StDrain: begin
               if (cnt_d == '0) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_error      = error_q;
   assign o_mem_we     = 1'b0;
   assign o_mem_cyc    = cyc_q;
   assign o_mem_stb    = stb_q;
   assign o_mem_sel    = stb_q ? 4'hF : 4'h0;
   assign o_mem_adr    = addr_q;
   assign o_mem_dat    = '0;
   assign o_data_valid = (cnt_q != '0);
   assign o_data       = o_data_valid ? fifo_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_wb_mem_dma_reader.sv
// Bench for wb_mem_dma_reader: randomized Wishbone slave plus a queue-based model of the
// expected word stream, bus address sequence and FIFO occupancy, checked every cycle.
module tb_wb_mem_dma_reader;

   logic        clk, rst;
   logic        start;
   logic [31:0] base;
   logic [23:0] wcount;
   logic        o_busy, o_done, o_error;
   logic        o_mem_we, o_mem_cyc, o_mem_stb;
   logic [3:0]  o_mem_sel;
   logic [31:0] o_mem_adr, o_mem_dat;
   logic [31:0] mem_idat;
   logic        mem_ack, mem_int;
   logic [31:0] o_data;
   logic        o_data_valid, ready;

   wb_mem_dma_reader #(
      .FIFO_ADDR_WIDTH(4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (start),
      .i_base_addr  (base),
      .i_word_count (wcount),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_error      (o_error),
      .o_mem_we     (o_mem_we),
      .o_mem_cyc    (o_mem_cyc),
      .o_mem_stb    (o_mem_stb),
      .o_mem_sel    (o_mem_sel),
      .o_mem_adr    (o_mem_adr),
      .o_mem_dat    (o_mem_dat),
      .i_mem_dat    (mem_idat),
      .i_mem_ack    (mem_ack),
      .i_mem_int    (mem_int),
      .o_data       (o_data),
      .o_data_valid (o_data_valid),
      .i_data_ready (ready)
   );

   int          total = 0;
   int          bad = 0;
   logic [31:0] bram [256];
   logic [31:0] expq [$];
   logic [31:0] got_q [$];
   logic [31:0] exp_adr;
   int          occ, acks, dones, stb_cycles, slave_wait, ready_mode;
   logic        chk_en, cyc_seen, err_at_done, mute, stray_ack;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Wishbone slave: random ack delay of 0..3 cycles, junk data except on ack.
   initial begin
      slave_wait = 0;
      mem_ack = 1'b0;
      mem_idat = '0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         mem_idat = $urandom;
         if (stray_ack && !o_mem_stb) begin
            mem_ack = 1'b1;
         end else if (!mute && o_mem_cyc && o_mem_stb) begin
            if (slave_wait == 0) begin
               mem_ack = 1'b1;
               mem_idat = bram[o_mem_adr[7:0]];
               slave_wait = $urandom_range(0, 3);
            end else begin
               slave_wait--;
            end
         end
      end
   end

   initial begin
      ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
         endcase
      end
   end

   // Compare process: model of stream order, bus address and FIFO occupancy.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         if (o_done) begin
            dones++;
            err_at_done = o_error;
            if (o_error) occ = 0;
         end
         check("bus_const", {o_mem_we, o_mem_dat != 32'd0, o_mem_sel},
               {1'b0, 1'b0, (o_mem_stb ? 4'hF : 4'h0)});
         check("stb_needs_cyc", o_mem_stb & ~o_mem_cyc, 0);
         check("valid", o_data_valid, occ != 0);
         if (o_mem_stb) begin
            check("adr", o_mem_adr, exp_adr);
            check("slot_free", occ < 16, 1);
            stb_cycles++;
         end
         if (o_mem_cyc) cyc_seen = 1'b1;
         if (o_data_valid && ready) begin
            if (expq.size() == 0) check("stream_extra", 1, 0);
            else check("stream_data", o_data, expq.pop_front());
            got_q.push_back(o_data);
            if (occ > 0) occ--;
         end
         if (o_mem_stb && mem_ack) begin
            acks++;
            exp_adr++;
            occ++;
         end
      end
   end

   task automatic prep_block(input logic [31:0] b, input int n);
      exp_adr = b;
      for (int i = 0; i < n; i++) expq.push_back(bram[8'(b + 32'(i))]);
      acks = 0;
      dones = 0;
      got_q.delete();
   endtask

   task automatic pulse_start(input logic [31:0] b, input logic [23:0] n);
      base = b;
      wcount = n;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (dones == 0 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_seen", dones != 0, 1);
   endtask

   task automatic run_block(input logic [31:0] b, input int n, input int mode);
      ready_mode = mode;
      prep_block(b, n);
      pulse_start(b, 24'(n));
      check("err_clear", o_error, 0);
      wait_done(3000);
      repeat (3) begin @(posedge clk); #1; end
      check("stream_len", expq.size(), 0);
      check("one_done", dones, 1);
      check("no_error", err_at_done, 0);
      check("ack_count", acks, n);
      check("idle_after", o_busy, 0);
   endtask

   initial begin
      int n;
      chk_en = 1'b0; mute = 1'b0; stray_ack = 1'b0; ready_mode = 0;
      occ = 0; acks = 0; dones = 0; stb_cycles = 0; exp_adr = '0;
      cyc_seen = 1'b0; err_at_done = 1'b0;
      rst = 1'b1; start = 1'b0; base = '0; wcount = '0; mem_int = 1'b0;
      for (int i = 0; i < 256; i++) bram[i] = $urandom;
      for (int i = 0; i < 4; i++) bram[16 + i] = 32'hA0 + 32'(i);
      repeat (3) begin @(posedge clk); #1; end
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_error", o_error, 0);
      check("rst_cyc_stb", {o_mem_cyc, o_mem_stb, o_mem_sel}, 0);
      check("rst_adr", o_mem_adr, 0);
      check("rst_stream", {o_data_valid, o_data}, 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Basic block with latency pinned: busy at T+1, stb at T+2.
      ready_mode = 0;
      prep_block(32'h10, 4);
      pulse_start(32'h10, 24'd4);
      check("busy_t1", o_busy, 1);
      check("stb_t1", o_mem_stb, 0);
      @(posedge clk); #1;
      check("stb_t2", o_mem_stb, 1);
      check("adr_t2", o_mem_adr, 32'h10);
      wait_done(200);
      repeat (2) begin @(posedge clk); #1; end
      check("basic_len", got_q.size(), 4);
      check("basic_w0", got_q[0], 32'hA0);
      check("basic_w3", got_q[3], 32'hA3);
      check("basic_done", dones, 1);

      // Empty block: one-cycle done with busy, no bus cycle.
      prep_block(32'h30, 0);
      cyc_seen = 1'b0;
      pulse_start(32'h30, 24'd0);
      check("zero_done_t1", {o_done, o_busy}, 2'b11);
      @(posedge clk); #1;
      check("zero_done_t2", {o_done, o_busy}, 2'b00);
      repeat (4) begin @(posedge clk); #1; end
      check("zero_no_cyc", cyc_seen, 0);
      check("zero_one_done", dones, 1);

      // Backpressure: FIFO fills, stb stops after 16 acks with cyc held.
      ready_mode = 2;
      prep_block(32'h60, 40);
      pulse_start(32'h60, 24'd40);
      n = 0;
      while (acks < 16 && n < 400) begin @(posedge clk); #1; n++; end
      repeat (10) begin @(posedge clk); #1; end
      check("full_acks", acks, 16);
      check("full_hold", {o_mem_cyc, o_mem_stb, o_busy, o_data_valid}, 4'b1011);
      ready_mode = 1;
      wait_done(3000);
      repeat (2) begin @(posedge clk); #1; end
      check("full_len", got_q.size(), 40);
      check("full_stream_left", expq.size(), 0);

      // Slave never acks: timeout after 8 stb cycles, error sticks until next start.
      mute = 1'b1;
      ready_mode = 0;
      prep_block(32'h20, 0);
      stb_cycles = 0;
      pulse_start(32'h20, 24'd3);
      wait_done(100);
      repeat (2) begin @(posedge clk); #1; end
      check("tmo_error_at_done", err_at_done, 1);
      check("tmo_stb_cycles", stb_cycles, 8);
      check("tmo_idle", {o_busy, o_mem_cyc, o_mem_stb, o_data_valid}, 0);
      stray_ack = 1'b1;
      @(posedge clk); #1;
      stray_ack = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("late_ack_ignored", {o_data_valid, o_busy}, 0);
      check("tmo_one_done", dones, 1);
      check("error_sticky", o_error, 1);
      mute = 1'b0;
      run_block(32'h80, 5, 0);

      // Second start while busy must be ignored.
      ready_mode = 1;
      prep_block(32'h50, 8);
      pulse_start(32'h50, 24'd8);
      repeat (3) begin @(posedge clk); #1; end
      pulse_start(32'h90, 24'd5);
      wait_done(1000);
      repeat (5) begin @(posedge clk); #1; end
      check("busy_start_done", dones, 1);
      check("busy_start_acks", acks, 8);
      check("busy_start_len", expq.size(), 0);

      // Reset after 3 of 8 acks aborts at once, then a new block completes.
      ready_mode = 0;
      prep_block(32'h40, 8);
      pulse_start(32'h40, 24'd8);
      n = 0;
      while (acks < 3 && n < 200) begin @(posedge clk); #1; n++; end
      check("rst_wait_acks", acks, 3);
      chk_en = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_rst_outputs", {o_mem_cyc, o_mem_stb, o_data_valid, o_busy, o_done}, 0);
      expq.delete();
      occ = 0;
      chk_en = 1'b1;
      run_block(32'h0, 2, 0);

      // Randomized blocks, including one straddling the address wrap.
      run_block(32'hFFFF_FFFC, 8, 1);
      for (int k = 0; k < 6; k++) begin
         run_block($urandom, int'($urandom_range(1, 40)), int'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
